// File: rtl/seq_count_param_updown.sv
// seq_count_param_updown: parametrised up/down counter with clear, load, modulus, wrap or saturate
// Define SEQ_COUNT_WRAP_CNT_EN to add the saturating wrap_cnt event tally.
module seq_count_param_updown #(
  parameter int NBITS = 3,
  parameter int MAX = 2**NBITS-1,
  parameter int RESET_VAL = 0,
  parameter bit SAT = 1'b0,
  parameter int WBITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  input  logic load,
  input  logic [NBITS-1:0] load_val,
  input  logic dir,
  output logic [NBITS-1:0] out,
  output logic at_max,
  output logic at_min,
`ifdef SEQ_COUNT_WRAP_CNT_EN
  output logic wrap,
  output logic [WBITS-1:0] wrap_cnt
`else
  output logic wrap
`endif
);
  localparam logic [NBITS-1:0] MAX_V = MAX[NBITS-1:0];
  localparam logic [NBITS-1:0] RST_V = RESET_VAL[NBITS-1:0];
  logic [NBITS-1:0] ld_v, out_nxt;
  logic at_end, wrap_nxt;
  // Clamping is only needed when codes above MAX exist.
  if (MAX < 2**NBITS-1) begin : g_clamp
    assign ld_v = load_val > MAX_V ? MAX_V : load_val;
  end else begin : g_noclamp
    assign ld_v = load_val;
  end
  assign at_max = out == MAX_V;
  assign at_min = out == '0;
  always_comb begin
    at_end = dir ? at_max : at_min;
    wrap_nxt = !clear && !load && en && at_end;
    out_nxt = clear ? '0 :
              load ? ld_v :
              !en ? out :
              !at_end ? (dir ? out + 1'b1 : out - 1'b1) :
              SAT ? out :
              dir ? '0 : MAX_V;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out <= RST_V;
      wrap <= 1'b0;
    end else begin
      out <= out_nxt;
      wrap <= wrap_nxt;
    end
`ifdef SEQ_COUNT_WRAP_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) wrap_cnt <= '0;
    else if (clear) wrap_cnt <= '0;
    else if (wrap_nxt && !(&wrap_cnt)) wrap_cnt <= wrap_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_seq_count_param_updown.sv
// tb_seq_count_param_updown: table-driven scoreboard bench over four counter configurations
module tb_seq_count_param_updown;
  logic clk = 1'b0, reset = 1'b0, clear = 1'b0, load = 1'b0, en = 1'b0, dir = 1'b0;
  logic [3:0] lv = '0;
  logic [2:0] o0, o2;
  logic [3:0] o1;
  logic [0:0] o3;
  logic [3:0] am, an, wr;
`ifdef SEQ_COUNT_WRAP_CNT_EN
  logic [7:0] wc0, wc1, wc2;
  logic [1:0] wc3;
`endif
  always #5 clk = ~clk;

  seq_count_param_updown #(.NBITS(3)) u0 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(lv[2:0]), .dir(dir),
    .out(o0), .at_max(am[0]), .at_min(an[0]),
`ifdef SEQ_COUNT_WRAP_CNT_EN
    .wrap(wr[0]), .wrap_cnt(wc0)
`else
    .wrap(wr[0])
`endif
  );
  seq_count_param_updown #(.NBITS(4), .MAX(9)) u1 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(lv), .dir(dir),
    .out(o1), .at_max(am[1]), .at_min(an[1]),
`ifdef SEQ_COUNT_WRAP_CNT_EN
    .wrap(wr[1]), .wrap_cnt(wc1)
`else
    .wrap(wr[1])
`endif
  );
  seq_count_param_updown #(.NBITS(3), .MAX(5), .RESET_VAL(2), .SAT(1'b1)) u2 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(lv[2:0]), .dir(dir),
    .out(o2), .at_max(am[2]), .at_min(an[2]),
`ifdef SEQ_COUNT_WRAP_CNT_EN
    .wrap(wr[2]), .wrap_cnt(wc2)
`else
    .wrap(wr[2])
`endif
  );
  seq_count_param_updown #(.NBITS(1), .MAX(1), .WBITS(2)) u3 (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load), .load_val(lv[0:0]), .dir(dir),
    .out(o3), .at_max(am[3]), .at_min(an[3]),
`ifdef SEQ_COUNT_WRAP_CNT_EN
    .wrap(wr[3]), .wrap_cnt(wc3)
`else
    .wrap(wr[3])
`endif
  );

  typedef struct {int i; bit rs, cl, ld, en, dir; logic [3:0] lv, eo; logic ew; logic [1:0] ewc;} vec_t;
  typedef struct {int i; logic [3:0] eo; logic ew; logic [1:0] ewc;} exp_t;
  vec_t vt[$];
  exp_t sb[$];
  int total = 0, bad = 0;
  int maxv[4] = '{7, 9, 5, 1};

  function automatic void add(int i, bit rs, cl, ld, en, dir, int lv, int eo, bit ew, int ewc = 0);
    vt.push_back('{i, rs, cl, ld, en, dir, 4'(lv), 4'(eo), ew, 2'(ewc)});
  endfunction

  function automatic logic [3:0] out_of(int i);
    return i == 0 ? {1'b0, o0} : i == 1 ? o1 : i == 2 ? {1'b0, o2} : {3'b0, o3};
  endfunction

  function automatic void chk(string nm, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void check(exp_t e, int r);
    chk($sformatf("u%0d row%0d out", e.i, r), out_of(e.i), e.eo);
    chk($sformatf("u%0d row%0d wrap", e.i, r), {3'b0, wr[e.i]}, {3'b0, e.ew});
    chk($sformatf("u%0d row%0d at_max", e.i, r), {3'b0, am[e.i]}, {3'b0, e.eo == 4'(maxv[e.i])});
    chk($sformatf("u%0d row%0d at_min", e.i, r), {3'b0, an[e.i]}, {3'b0, e.eo == 4'd0});
`ifdef SEQ_COUNT_WRAP_CNT_EN
    if (e.i == 3) chk($sformatf("u3 row%0d wrap_cnt", r), {2'b0, wc3}, {2'b0, e.ewc});
`endif
  endfunction

  initial begin
    exp_t e;
    int wc;
    // u0: NBITS=3 MAX=7 wrap mode
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, 0, 0, 0, 1, 1, 0, k % 8, k == 8);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 1, 0, 2, 0);
    for (int k = 3; k <= 6; k++) add(0, 0, 0, 0, 1, 1, 0, k, 0);
    add(0, 1, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 1, 1, 1, 1, 5, 0, 0);
    add(0, 0, 0, 1, 1, 1, 5, 5, 0);
    add(0, 0, 0, 0, 1, 0, 0, 4, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 7, 1);
    add(0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 3, 3, 0);
    add(0, 0, 0, 0, 0, 0, 6, 3, 0);
    // u1: NBITS=4 MAX=9 counting down
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 9, 1);
    for (int k = 8; k >= 0; k--) add(1, 0, 0, 0, 1, 0, 0, k, 0);
    add(1, 0, 0, 0, 1, 0, 0, 9, 1);
    add(1, 0, 0, 0, 1, 0, 0, 8, 0);
    add(1, 0, 0, 1, 1, 0, 12, 9, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0, 1);
    // u2: NBITS=3 MAX=5 RESET_VAL=2 saturate
    add(2, 1, 0, 0, 0, 0, 0, 2, 0);
    add(2, 0, 0, 1, 1, 1, 4, 4, 0);
    add(2, 0, 0, 0, 1, 1, 0, 5, 0);
    for (int k = 0; k < 3; k++) add(2, 0, 0, 0, 1, 1, 0, 5, 1);
    add(2, 0, 0, 0, 0, 1, 0, 5, 0);
    add(2, 0, 0, 1, 1, 1, 7, 5, 0);
    add(2, 0, 0, 1, 0, 0, 0, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0, 0, 1);
    add(2, 0, 0, 0, 1, 0, 0, 0, 1);
    add(2, 0, 0, 0, 1, 1, 0, 1, 0);
    // u3: NBITS=1 MAX=1 WBITS=2 tally saturation
    add(3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    wc = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k % 2 == 0 && wc < 3) wc++;
      add(3, 0, 0, 0, 1, 1, 0, k % 2, k % 2 == 0, wc);
    end
    add(3, 0, 0, 1, 0, 1, 1, 1, 0, 3);
    add(3, 0, 1, 0, 1, 1, 0, 0, 0, 0);

    foreach (vt[k]) begin
      @(negedge clk);
      {clear, load, en, dir, lv} = {vt[k].cl, vt[k].ld, vt[k].en, vt[k].dir, vt[k].lv};
      sb.push_back('{vt[k].i, vt[k].eo, vt[k].ew, vt[k].ewc});
      if (vt[k].rs) begin
        reset = 1'b1;
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: no expected entry at row %0d", k);
      end else begin
        e = sb.pop_front();
        check(e, k);
      end
      if (vt[k].rs) {reset, clear, load, en} = 4'b0;
    end

    // Reset arriving right after a wrap/saturation edge must drop the pulse at once.
    @(negedge clk);
    {clear, load, en, dir, lv} = {1'b0, 1'b1, 1'b0, 1'b1, 4'd7};
    @(posedge clk);
    #1;
    {load, en} = 2'b01;
    @(posedge clk);
    #1;
    chk("abort u0 out pre", out_of(0), 4'd0);
    chk("abort u0 wrap pre", {3'b0, wr[0]}, 4'd1);
    chk("abort u2 out pre", out_of(2), 4'd5);
    chk("abort u2 wrap pre", {3'b0, wr[2]}, 4'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort u0 wrap", {3'b0, wr[0]}, 4'd0);
    chk("abort u2 out", out_of(2), 4'd2);
    chk("abort u2 wrap", {3'b0, wr[2]}, 4'd0);
    reset = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort u2 hold", out_of(2), 4'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
